temp_bcd_converter: RTL and testbench

Converts one raw two-byte temperature reading from the I2C sensor (13-bit two's-complement, 0.0625 °C/LSB, left-justified in MSB:LSB) into a sign flag plus hundreds/tens/ones/tenths BCD digits. It sits between the sensor-read sequencer, which produces the MSB/LSB byte pair, and the seven-segment Display driver, which consumes the digits. Integer conversion is a sequential double-dabble loop, one shift per cycle, with a start/busy/done handshake.

---
 rtl/temp_bcd_converter_pkg.sv | 26 ++
 rtl/temp_bcd_converter_dd_step.sv | 21 ++
 rtl/temp_bcd_converter.sv | 102 ++++++++++
 tb/tb_temp_bcd_converter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/temp_bcd_converter_pkg.sv
// Shared types and constants for the sensor temperature to BCD converter.
// Sensor format: 13-bit two's complement, 1/16 degree per LSB.
`timescale 1ns/1ps
package temp_bcd_converter_pkg;

    localparam int INT_BITS   = 9;
    localparam int FRAC_BITS  = 4;
    localparam int CONV_STEPS = INT_BITS;
    localparam int BCD_DIGITS = 3;
    localparam int RAW_W      = INT_BITS + FRAC_BITS;
    localparam int SR_W       = 4 * BCD_DIGITS + INT_BITS;

    localparam logic [3:0] ADD3_THRESH = 4'd5;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CONV,
        DONE
    } state_t;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= ADD3_THRESH) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/temp_bcd_converter_dd_step.sv
// One double-dabble iteration: add 3 to any BCD nibble >= 5,
// then shift the whole {hund,tens,ones,int} vector left by one.
`timescale 1ns/1ps
module dd_step
    import temp_bcd_converter_pkg::*;
(
    input  logic [SR_W-1:0] i_sr,
    output logic [SR_W-1:0] o_sr
);

    logic [SR_W-1:0] w_adj;

    always_comb begin
        w_adj = i_sr;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            w_adj[INT_BITS + 4*d +: 4] = add3(i_sr[INT_BITS + 4*d +: 4]);
        end
        o_sr = w_adj << 1;
    end

endmodule

// File: rtl/temp_bcd_converter.sv
// Raw sensor bytes -> sign + hundreds/tens/ones/tenths BCD digits.
// Integer part converted by a sequential double-dabble loop, one shift per cycle.
`timescale 1ns/1ps
module temp_bcd_converter
    import temp_bcd_converter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] msb,
    input  logic [7:0] lsb,
    output logic       busy,
    output logic       done,
    output logic       neg,
    output logic [3:0] hund,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [3:0] tenth
);

    state_t           r_state;
    logic [RAW_W-1:0] r_raw;
    logic [SR_W-1:0]  r_sr;
    logic [3:0]       r_cnt;
    logic             r_neg;
    logic [3:0]       r_tenth;

    logic             w_neg;
    logic [RAW_W-1:0] w_mag;
    logic [3:0]       w_tenth;
    logic [SR_W-1:0]  w_sr_next;
    logic             w_unused_flags;

    // Low three bits of the LSB byte are sensor status flags.
    assign w_unused_flags = ^lsb[2:0];

    // -4096 negates to 4096, which still fits the unsigned 13-bit magnitude.
    assign w_neg   = r_raw[RAW_W-1];
    assign w_mag   = w_neg ? (~r_raw + RAW_W'(1)) : r_raw;
    assign w_tenth = 4'(({4'b0, w_mag[FRAC_BITS-1:0]} * 8'd10) >> FRAC_BITS);

    dd_step u_dd_step (
        .i_sr (r_sr),
        .o_sr (w_sr_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_raw   <= '0;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_tenth <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            neg     <= 1'b0;
            hund    <= '0;
            tens    <= '0;
            ones    <= '0;
            tenth   <= '0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_raw   <= {msb, lsb[7:3]};
                        busy    <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_neg   <= w_neg;
                    r_tenth <= w_tenth;
                    r_sr    <= {{(4*BCD_DIGITS){1'b0}},
                                w_mag[FRAC_BITS +: INT_BITS]};
                    r_cnt   <= '0;
                    r_state <= CONV;
                end
                CONV: begin
                    r_sr  <= w_sr_next;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'(CONV_STEPS - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    hund    <= r_sr[SR_W-1 -: 4];
                    tens    <= r_sr[SR_W-5 -: 4];
                    ones    <= r_sr[SR_W-9 -: 4];
                    neg     <= r_neg;
                    tenth   <= r_tenth;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_bcd_converter.sv
// Self-checking bench for temp_bcd_converter: directed plan cases,
// random readings vs an arithmetic reference model, handshake and reset.
`timescale 1ns/1ps
module tb_temp_bcd_converter;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] msb;
    logic [7:0] lsb;
    logic       busy;
    logic       done;
    logic       neg;
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] tenth;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    temp_bcd_converter dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .msb   (msb),
        .lsb   (lsb),
        .busy  (busy),
        .done  (done),
        .neg   (neg),
        .hund  (hund),
        .tens  (tens),
        .ones  (ones),
        .tenth (tenth)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the signed reading.
    task automatic model(input logic [7:0] m, input logic [7:0] l,
                         output int e_neg, output int e_h, output int e_t,
                         output int e_o, output int e_f);
        int tv;
        int mag;
        int ip;
        tv    = int'($signed({m, l})) >>> 3;
        e_neg = (tv < 0) ? 1 : 0;
        mag   = (tv < 0) ? -tv : tv;
        ip    = mag / 16;
        e_f   = ((mag % 16) * 10) / 16;
        e_h   = ip / 100;
        e_t   = (ip / 10) % 10;
        e_o   = ip % 10;
    endtask

    task automatic check_result(input string tag, input logic [7:0] m,
                                input logic [7:0] l);
        int e_neg, e_h, e_t, e_o, e_f;
        model(m, l, e_neg, e_h, e_t, e_o, e_f);
        check({tag, ".neg"},   neg,   e_neg);
        check({tag, ".hund"},  hund,  e_h);
        check({tag, ".tens"},  tens,  e_t);
        check({tag, ".ones"},  ones,  e_o);
        check({tag, ".tenth"}, tenth, e_f);
    endtask

    // Caller sits #1 after an edge; returns #1 after the sampling edge.
    task automatic kick(input logic [7:0] m, input logic [7:0] l);
        msb   = m;
        lsb   = l;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic convert(input string tag, input logic [7:0] m,
                           input logic [7:0] l);
        int lat;
        kick(m, l);
        wait_done(lat);
        check({tag, ".latency"}, lat, 11);
        check({tag, ".busy_in_done"}, busy, 0);
        check_result(tag, m, l);
    endtask

    logic [15:0] dir [8] = '{16'h0C88, 16'h4B00, 16'h7FF8, 16'hE480,
                             16'hFFF8, 16'h8000, 16'h1907, 16'h1900};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ndone;
        int dcyc;
        logic [7:0] rm;
        logic [7:0] rl;

        reset = 1'b1;
        start = 1'b0;
        msb   = 8'h00;
        lsb   = 8'h00;
        #1;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check_result("rst", 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (dir[i]) begin
            convert($sformatf("dir%0d", i), dir[i][15:8], dir[i][7:0]);
        end
        convert("m55_const", 8'hE4, 8'h80);
        check("m55_const.tens_lit", tens, 5);
        check("m55_const.neg_lit", neg, 1);
        convert("min_const", 8'h80, 8'h00);
        check("min_const.digits_lit", {hund, tens, ones}, 12'h256);

        for (int i = 0; i < 30; i++) begin
            rm = 8'($urandom);
            rl = 8'($urandom);
            convert($sformatf("rnd%0d", i), rm, rl);
        end

        repeat (5) @(posedge clk);
        #1;
        check_result("hold", rm, rl);
        check("hold.done", done, 0);

        kick(8'h0C, 8'h88);
        ndone = 0;
        dcyc  = -1;
        for (int c = 1; c <= 20; c++) begin
            if (c == 3 || c == 7) begin
                msb   = 8'h7F;
                lsb   = 8'hF8;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                dcyc = c;
                check_result("repulse", 8'h0C, 8'h88);
            end
        end
        check("repulse.done_count", ndone, 1);
        check("repulse.done_cycle", dcyc, 11);

        convert("b2b_a", 8'h7F, 8'hF8);
        convert("b2b_b", 8'h19, 8'h00);

        convert("pre_rst", 8'h7F, 8'hF8);
        kick(8'h4B, 8'h00);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst.busy", busy, 0);
        check("midrst.done", done, 0);
        check_result("midrst", 8'h00, 8'h00);
        #1;
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("midrst.no_done", ndone, 0);
        check("midrst.busy_after", busy, 0);
        convert("post_rst", 8'hE4, 8'h80);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
